// File: rtl/uvmt_reset_st_rst_seq_pkg.sv
// Shared types and sizing helpers for the sequenced reset release block.
package uvmt_reset_st_rst_seq_pkg;

   // Sequencer phases: hold, debounce, per-domain release, inter-release gap, finished
   typedef enum logic [2:0] {
      ASSERT  = 3'd0,
      FILTER  = 3'd1,
      RELEASE = 3'd2,
      GAP     = 3'd3,
      DONE    = 3'd4
   } rst_seq_state_t;

   // Counter width wide enough for the largest cycle parameter, plus one spare bit
   function automatic int rst_seq_cnt_width(input int min_assert, input int filter,
                                            input int gap, input int ack_timeout);
      int m;
      m = min_assert;
      if (filter > m) m = filter;
      if (gap > m) m = gap;
      if (ack_timeout > m) m = ack_timeout;
      if (m < 1) m = 1;
      return $clog2(m) + 1;
   endfunction

   // Domain index width, never narrower than one bit
   function automatic int rst_seq_idx_width(input int num_domains);
      return (num_domains > 1) ? $clog2(num_domains) : 1;
   endfunction

endpackage

// File: rtl/uvmt_reset_st_rst_seq_cnt.sv
// Clear/enable up-counter with a terminal-count compare. One instance is time
// shared between the assert hold, the deassert filter, the release gap and the
// optional ack timeout; the owner selects the terminal value per phase.
module uvmt_reset_st_rst_seq_cnt #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] tc_value,
   output logic             tc
);

   logic [WIDTH-1:0] count;

   // Count up while enabled; clear has priority over enable
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + WIDTH'(1);
      end
   end

   assign tc = (count == tc_value);

endmodule

// File: rtl/uvmt_reset_st_rst_seq.sv
// Sequenced reset release: holds all domain resets for a minimum width, filters
// glitchy deassertion of reset_req, then releases domains one at a time in index
// order, each waiting for its ack and followed by a fixed gap.
// Optional ack timeout enabled by defining UVMT_RESET_ST_RST_SEQ_ACK_TIMEOUT_EN.
module uvmt_reset_st_rst_seq
   import uvmt_reset_st_rst_seq_pkg::*;
#(
   parameter int NUM_DOMAINS        = 4,
   parameter int MIN_ASSERT_CYCLES  = 8,
   parameter int FILTER_CYCLES      = 4,
   parameter int GAP_CYCLES         = 2,
   parameter int ACK_TIMEOUT_CYCLES = 64
) (
   input  logic                                        clk,
   input  logic                                        reset,
   input  logic                                        reset_req,
   input  logic [NUM_DOMAINS-1:0]                      domain_ack,
   output logic [NUM_DOMAINS-1:0]                      rst_out,
   output logic [rst_seq_idx_width(NUM_DOMAINS)-1:0]   cur_domain,
   output logic                                        busy,
   output logic                                        seq_done,
   output logic                                        timeout_err
);

   localparam int DOM_W = rst_seq_idx_width(NUM_DOMAINS);
   localparam int CNT_W = rst_seq_cnt_width(MIN_ASSERT_CYCLES, FILTER_CYCLES,
                                            GAP_CYCLES, ACK_TIMEOUT_CYCLES);
`ifdef UVMT_RESET_ST_RST_SEQ_ACK_TIMEOUT_EN
   localparam logic TIMEOUT_EN = 1'b1;
`else
   localparam logic TIMEOUT_EN = 1'b0;
`endif

   rst_seq_state_t         state;
   rst_seq_state_t         state_nxt;
   logic [NUM_DOMAINS-1:0] rst_nxt;
   logic [DOM_W-1:0]       dom_nxt;
   logic [DOM_W-1:0]       dom_inc;
   logic [CNT_W-1:0]       tc_value;
   logic                   ack_sel;
   logic                   last_dom;
   logic                   cnt_clr;
   logic                   cnt_en;
   logic                   cnt_tc;
   logic                   timeout_hit;
`ifdef UVMT_RESET_ST_RST_SEQ_ACK_TIMEOUT_EN
   logic                   tout_nxt;
`endif

   assign dom_inc     = cur_domain + DOM_W'(1);
   assign last_dom    = (cur_domain == DOM_W'(NUM_DOMAINS - 1));
   assign timeout_hit = TIMEOUT_EN & cnt_tc;

   // Pick only the ack of the domain under release so X on other bits is never observed
   always_comb begin
      ack_sel = 1'b0;
      for (int i = 0; i < NUM_DOMAINS; i++) begin
         if (cur_domain == DOM_W'(i)) ack_sel = domain_ack[i];
      end
   end

   // Terminal count for whichever phase currently owns the shared counter
   always_comb begin
      tc_value = CNT_W'(MIN_ASSERT_CYCLES - 1);
      case (state)
         FILTER:  tc_value = CNT_W'(FILTER_CYCLES - 1);
         GAP:     tc_value = CNT_W'(GAP_CYCLES - 1);
         RELEASE: tc_value = CNT_W'(ACK_TIMEOUT_CYCLES - 1);
         default: tc_value = CNT_W'(MIN_ASSERT_CYCLES - 1);
      endcase
   end

   uvmt_reset_st_rst_seq_cnt #(
      .WIDTH (CNT_W)
   ) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .clr      (cnt_clr),
      .en       (cnt_en),
      .tc_value (tc_value),
      .tc       (cnt_tc)
   );

   // Next-state decode; an abort from reset_req is applied last so it beats acks and expiries
   always_comb begin
      state_nxt = state;
      rst_nxt   = rst_out;
      dom_nxt   = cur_domain;
      cnt_clr   = 1'b0;
      cnt_en    = 1'b0;
`ifdef UVMT_RESET_ST_RST_SEQ_ACK_TIMEOUT_EN
      tout_nxt  = timeout_err;
`endif
      case (state)
         ASSERT: begin
            rst_nxt = '1;
            if (cnt_tc && !reset_req) begin
               state_nxt = FILTER;
               cnt_clr   = 1'b1;
            end else if (!cnt_tc) begin
               cnt_en = 1'b1;
            end
         end
         FILTER: begin
            if (cnt_tc) begin
               state_nxt  = RELEASE;
               cnt_clr    = 1'b1;
               dom_nxt    = '0;
               rst_nxt[0] = 1'b0;
            end else begin
               cnt_en = 1'b1;
            end
         end
         RELEASE: begin
            if (ack_sel || timeout_hit) begin
`ifdef UVMT_RESET_ST_RST_SEQ_ACK_TIMEOUT_EN
               if (!ack_sel) tout_nxt = 1'b1;
`endif
               cnt_clr = 1'b1;
               if (last_dom) begin
                  state_nxt = DONE;
                  rst_nxt   = '0;
               end else if (GAP_CYCLES == 0) begin
                  dom_nxt = dom_inc;
                  for (int i = 0; i < NUM_DOMAINS; i++) begin
                     if (dom_inc == DOM_W'(i)) rst_nxt[i] = 1'b0;
                  end
               end else begin
                  state_nxt = GAP;
               end
            end else begin
               cnt_en = TIMEOUT_EN;
            end
         end
         GAP: begin
            if (cnt_tc) begin
               state_nxt = RELEASE;
               cnt_clr   = 1'b1;
               dom_nxt   = dom_inc;
               for (int i = 0; i < NUM_DOMAINS; i++) begin
                  if (dom_inc == DOM_W'(i)) rst_nxt[i] = 1'b0;
               end
            end else begin
               cnt_en = 1'b1;
            end
         end
         DONE: begin
            rst_nxt = '0;
         end
         default: begin
            state_nxt = ASSERT;
            rst_nxt   = '1;
            dom_nxt   = '0;
            cnt_clr   = 1'b1;
         end
      endcase

      if (reset_req && (state != ASSERT)) begin
         state_nxt = ASSERT;
         rst_nxt   = '1;
         dom_nxt   = '0;
         cnt_clr   = 1'b1;
         cnt_en    = 1'b0;
`ifdef UVMT_RESET_ST_RST_SEQ_ACK_TIMEOUT_EN
         tout_nxt  = 1'b0;
`endif
      end
   end

   // Register state and all outputs; block reset returns to the fully asserted hold
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ASSERT;
         rst_out    <= '1;
         cur_domain <= '0;
         busy       <= 1'b1;
         seq_done   <= 1'b0;
      end else begin
         state      <= state_nxt;
         rst_out    <= rst_nxt;
         cur_domain <= dom_nxt;
         busy       <= (state_nxt != DONE);
         seq_done   <= (state_nxt == DONE);
      end
   end

`ifdef UVMT_RESET_ST_RST_SEQ_ACK_TIMEOUT_EN
   // Sticky record that some domain was released without ever acking
   always_ff @(posedge clk) begin
      if (reset) begin
         timeout_err <= 1'b0;
      end else begin
         timeout_err <= tout_nxt;
      end
   end
`else
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uvmt_reset_st_rst_seq.sv
// Directed bench for uvmt_reset_st_rst_seq with default parameters.
// Cycle n means the nth rising edge after reset is dropped; outputs are
// sampled 1ns after each edge. Honours UVMT_RESET_ST_RST_SEQ_ACK_TIMEOUT_EN.
module tb_uvmt_reset_st_rst_seq;

   logic       clk;
   logic       reset;
   logic       reset_req;
   logic [3:0] domain_ack;
   logic [3:0] rst_out;
   logic [1:0] cur_domain;
   logic       busy;
   logic       seq_done;
   logic       timeout_err;

   int checks   = 0;
   int failures = 0;

   uvmt_reset_st_rst_seq #(
      .NUM_DOMAINS        (4),
      .MIN_ASSERT_CYCLES  (8),
      .FILTER_CYCLES      (4),
      .GAP_CYCLES         (2),
      .ACK_TIMEOUT_CYCLES (64)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .reset_req   (reset_req),
      .domain_ack  (domain_ack),
      .rst_out     (rst_out),
      .cur_domain  (cur_domain),
      .busy        (busy),
      .seq_done    (seq_done),
      .timeout_err (timeout_err)
   );

   // Free-running 100MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so a stuck run still reports
   initial begin
      #200000;
      failures++;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset(input logic req, input logic [3:0] ack);
      reset      = 1'b1;
      reset_req  = req;
      domain_ack = ack;
      step(2);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset      = 1'b1;
      reset_req  = 1'b1;
      domain_ack = 4'h0;
      step(2);
      checks++;
      if ({rst_out, cur_domain, busy, seq_done} !== {4'hF, 2'd0, 1'b1, 1'b0}) begin
         failures++;
         $display("[TB] FAIL reset_vals actual=%b/%0d/%b/%b required=1111/0/1/0", rst_out, cur_domain, busy, seq_done);
      end
      checks++;
      if (timeout_err !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_tout actual=%b required=0", timeout_err);
      end
      reset_req  = 1'b0;
      domain_ack = 4'hF;
      reset      = 1'b0;
      step(13);
      checks++;
      if (rst_out !== 4'b1110) begin
         failures++;
         $display("[TB] FAIL pre_midreset actual=%b required=1110", rst_out);
      end
      reset = 1'b1;
      step(1);
      checks++;
      if ({rst_out, cur_domain, busy, seq_done} !== {4'hF, 2'd0, 1'b1, 1'b0}) begin
         failures++;
         $display("[TB] FAIL mid_reset actual=%b/%0d/%b/%b required=1111/0/1/0", rst_out, cur_domain, busy, seq_done);
      end
   endtask

   task automatic test_default_sequence();
      logic [3:0] exp_rst;
      logic [1:0] exp_cur;
      logic       exp_done;
      logic       exp_busy;
      do_reset(1'b0, 4'hF);
      for (int n = 1; n <= 24; n++) begin
         step(1);
         exp_rst = 4'hF;
         for (int i = 0; i < 4; i++) if (n >= 12 + 3 * i) exp_rst[i] = 1'b0;
         exp_done = (n >= 22);
         exp_busy = (n < 22);
         exp_cur  = (n < 15) ? 2'd0 : (n < 18) ? 2'd1 : (n < 21) ? 2'd2 : 2'd3;
         checks++;
         if ({rst_out, seq_done, busy} !== {exp_rst, exp_done, exp_busy}) begin
            failures++;
            $display("[TB] FAIL default_seq cycle %0d actual=%b/%b/%b required=%b/%b/%b", n, rst_out, seq_done, busy, exp_rst, exp_done, exp_busy);
         end
         if (n <= 21) begin
            checks++;
            if (cur_domain !== exp_cur) begin
               failures++;
               $display("[TB] FAIL default_cur cycle %0d actual=%0d required=%0d", n, cur_domain, exp_cur);
            end
         end
      end
      checks++;
      if (timeout_err !== 1'b0) begin
         failures++;
         $display("[TB] FAIL default_tout actual=%b required=0", timeout_err);
      end
      reset_req = 1'b1;
      step(1);
      reset_req = 1'b0;
      checks++;
      if ({rst_out, cur_domain, busy, seq_done} !== {4'hF, 2'd0, 1'b1, 1'b0}) begin
         failures++;
         $display("[TB] FAIL done_abort actual=%b/%0d/%b/%b required=1111/0/1/0", rst_out, cur_domain, busy, seq_done);
      end
   endtask

   task automatic test_long_req();
      logic [3:0] exp_rst;
      do_reset(1'b1, 4'hF);
      step(20);
      checks++;
      if ({rst_out, busy} !== {4'hF, 1'b1}) begin
         failures++;
         $display("[TB] FAIL long_req_hold actual=%b/%b required=1111/1", rst_out, busy);
      end
      reset_req = 1'b0;
      for (int n = 21; n <= 25; n++) begin
         step(1);
         exp_rst = (n >= 25) ? 4'b1110 : 4'b1111;
         checks++;
         if (rst_out !== exp_rst) begin
            failures++;
            $display("[TB] FAIL long_req cycle %0d actual=%b required=%b", n, rst_out, exp_rst);
         end
      end
   endtask

   task automatic test_filter_glitch();
      logic [3:0] exp_rst;
      do_reset(1'b0, 4'hF);
      step(10);
      reset_req = 1'b1;
      step(1);
      reset_req = 1'b0;
      for (int n = 12; n <= 23; n++) begin
         step(1);
         exp_rst = (n >= 23) ? 4'b1110 : 4'b1111;
         checks++;
         if (rst_out !== exp_rst) begin
            failures++;
            $display("[TB] FAIL filter_glitch cycle %0d actual=%b required=%b", n, rst_out, exp_rst);
         end
      end
   endtask

   task automatic test_ack_stall();
      logic [3:0] exp_rst;
      do_reset(1'b0, 4'bxx01);
      for (int n = 1; n <= 45; n++) begin
         step(1);
         if (n >= 15) begin
            checks++;
            if ({rst_out, cur_domain, busy} !== {4'b1100, 2'd1, 1'b1}) begin
               failures++;
               $display("[TB] FAIL ack_stall cycle %0d actual=%b/%0d/%b required=1100/1/1", n, rst_out, cur_domain, busy);
            end
         end
      end
      domain_ack = 4'hF;
      for (int n = 46; n <= 52; n++) begin
         step(1);
         exp_rst = (n >= 51) ? 4'b0000 : (n >= 48) ? 4'b1000 : 4'b1100;
         checks++;
         if (rst_out !== exp_rst) begin
            failures++;
            $display("[TB] FAIL ack_resume cycle %0d actual=%b required=%b", n, rst_out, exp_rst);
         end
      end
      checks++;
      if (seq_done !== 1'b1) begin
         failures++;
         $display("[TB] FAIL ack_resume_done actual=%b required=1", seq_done);
      end
   endtask

   task automatic test_abort_on_ack();
      do_reset(1'b0, 4'hF);
      step(18);
      checks++;
      if ({rst_out, cur_domain} !== {4'b1000, 2'd2}) begin
         failures++;
         $display("[TB] FAIL abort_setup actual=%b/%0d required=1000/2", rst_out, cur_domain);
      end
      reset_req = 1'b1;
      step(1);
      reset_req = 1'b0;
      checks++;
      if ({rst_out, cur_domain, busy, seq_done} !== {4'hF, 2'd0, 1'b1, 1'b0}) begin
         failures++;
         $display("[TB] FAIL abort_wins actual=%b/%0d/%b/%b required=1111/0/1/0", rst_out, cur_domain, busy, seq_done);
      end
      step(11);
      checks++;
      if (rst_out !== 4'hF) begin
         failures++;
         $display("[TB] FAIL abort_restart_hold actual=%b required=1111", rst_out);
      end
      step(1);
      checks++;
      if (rst_out !== 4'b1110) begin
         failures++;
         $display("[TB] FAIL abort_restart_rel actual=%b required=1110", rst_out);
      end
   endtask

   task automatic test_timeout();
      do_reset(1'b0, 4'h0);
`ifdef UVMT_RESET_ST_RST_SEQ_ACK_TIMEOUT_EN
      for (int n = 1; n <= 274; n++) begin
         step(1);
         if (n == 75) begin
            checks++;
            if ({rst_out, timeout_err} !== {4'b1110, 1'b0}) begin
               failures++;
               $display("[TB] FAIL tout_before actual=%b/%b required=1110/0", rst_out, timeout_err);
            end
         end
         if (n == 76) begin
            checks++;
            if ({timeout_err, busy} !== {1'b1, 1'b1}) begin
               failures++;
               $display("[TB] FAIL tout_set actual=%b/%b required=1/1", timeout_err, busy);
            end
         end
         if (n == 78) begin
            checks++;
            if (rst_out !== 4'b1100) begin
               failures++;
               $display("[TB] FAIL tout_next_dom actual=%b required=1100", rst_out);
            end
         end
      end
      checks++;
      if ({rst_out, seq_done, timeout_err} !== {4'b0000, 1'b1, 1'b1}) begin
         failures++;
         $display("[TB] FAIL tout_done actual=%b/%b/%b required=0000/1/1", rst_out, seq_done, timeout_err);
      end
      reset_req = 1'b1;
      step(1);
      reset_req = 1'b0;
      checks++;
      if (timeout_err !== 1'b0) begin
         failures++;
         $display("[TB] FAIL tout_abort_clear actual=%b required=0", timeout_err);
      end
`else
      step(150);
      checks++;
      if ({rst_out, cur_domain, busy, seq_done} !== {4'b1110, 2'd0, 1'b1, 1'b0}) begin
         failures++;
         $display("[TB] FAIL no_tout_wait actual=%b/%0d/%b/%b required=1110/0/1/0", rst_out, cur_domain, busy, seq_done);
      end
      checks++;
      if (timeout_err !== 1'b0) begin
         failures++;
         $display("[TB] FAIL no_tout_flag actual=%b required=0", timeout_err);
      end
`endif
   endtask

   // Run every scenario in order, then report
   initial begin
      reset      = 1'b1;
      reset_req  = 1'b0;
      domain_ack = 4'h0;
      $display("[TB] starting uvmt_reset_st_rst_seq bench");
      test_reset();
      test_default_sequence();
      test_long_req();
      test_filter_glitch();
      test_ack_stall();
      test_abort_on_ack();
      test_timeout();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uvmt_reset_st_rst_seq.md
Name: uvmt_reset_st_rst_seq

Overview:
- Downstream consumer of the reset delay line in the reset ST bench; its reset_req input is the delayed reset from that stage.
- Enforces a minimum reset assertion width and filters glitchy deassertion.
- Releases NUM_DOMAINS per-domain resets one at a time, each gated by a per-domain ack handshake, with a fixed gap between releases.
- Gives the reset agent a multi-stage, sequential reset target to monitor.

Parameters:
- NUM_DOMAINS, 4, number of sequenced output resets (>=1).
- MIN_ASSERT_CYCLES, 8, minimum cycles all outputs stay asserted (>=1).
- FILTER_CYCLES, 4, consecutive low cycles of reset_req required before release starts (>=1).
- GAP_CYCLES, 2, idle cycles between an ack and the next domain release (0 = back-to-back).
- ACK_TIMEOUT_CYCLES, 64, ack wait limit; used only with the optional feature.

Ports:
- clk  input  1  single clock.
- reset  input  1  synchronous, active-high block reset.
- reset_req  input  1  active-high reset request from the delay line.
- domain_ack  input  NUM_DOMAINS  per-domain "out of reset" ack; bit i is sampled only while domain i is being released.
- rst_out  output  NUM_DOMAINS  active-high per-domain resets, registered.
- cur_domain  output  $clog2(NUM_DOMAINS) (min 1)  index of the domain being or next to be released.
- busy  output  1  high in every state except DONE.
- seq_done  output  1  high only in DONE.
- timeout_err  output  1  sticky ack-timeout flag.

Behaviour:
- Interface (already decided): one clock `clk`; reset port `reset`, synchronous, active-high.
- All state and outputs are registered and update on the clk rising edge.
- Reset values: state=ASSERT, cnt=0, rst_out all 1, cur_domain=0, busy=1, seq_done=0, timeout_err=0.
- States: ASSERT, FILTER, RELEASE, GAP, DONE.
- ASSERT:
  - rst_out all 1; cnt increments, saturating at MIN_ASSERT_CYCLES-1.
  - Exit to FILTER (cnt=0) when cnt==MIN_ASSERT_CYCLES-1 and reset_req==0.
  - Otherwise hold. A long reset_req extends ASSERT.
- FILTER:
  - rst_out all 1; cnt counts consecutive reset_req==0 cycles.
  - reset_req==1 -> ASSERT, cnt=0.
  - cnt==FILTER_CYCLES-1 with reset_req==0 -> RELEASE, cur_domain=0, and rst_out[0] clears on the same edge.
- RELEASE:
  - Wait for domain_ack[cur_domain]==1. An ack already high on entry is accepted in the first RELEASE cycle.
  - On ack: if cur_domain==NUM_DOMAINS-1 -> DONE.
  - Else if GAP_CYCLES==0 -> stay in RELEASE with cur_domain+1, and that rst_out bit clears on the same edge.
  - Else -> GAP, cnt=0.
- GAP:
  - cnt increments.
  - At cnt==GAP_CYCLES-1 -> RELEASE, cur_domain+1, and rst_out[cur_domain+1] clears on the same edge.
- DONE: rst_out all 0, busy=0, seq_done=1; hold until reset_req.
- Abort:
  - reset_req==1 in FILTER, RELEASE, GAP or DONE -> next edge: ASSERT, cnt=0, cur_domain=0, rst_out all 1, seq_done=0.
  - Abort has priority over a same-cycle ack or counter expiry.
- Once released, a domain stays released until abort; rst_out only ever goes 1->0 in index order.
- domain_ack bits for other indices are ignored; their X values must not propagate.
- Block reset overrides everything. A mid-sequence reset restarts at ASSERT.
- Timing with default parameters, reset_req=0, acks tied 1 (cycle n = nth edge after reset drops):
  - rst_out[0]=0 from cycle 12, [1] from 15, [2] from 18, [3] from 21.
  - seq_done=1 from cycle 22.

Optional Feature:
- Macro: UVMT_RESET_ST_RST_SEQ_ACK_TIMEOUT_EN.
- Defined:
  - RELEASE counts cycles without an ack.
  - At ACK_TIMEOUT_CYCLES the block sets timeout_err and proceeds exactly as if acked.
  - timeout_err is cleared by block reset or on entry to ASSERT via abort.
- Undefined: RELEASE waits forever, timeout_err is tied 0, and ACK_TIMEOUT_CYCLES is unused.

Decomposition:
- Package uvmt_reset_st_rst_seq_pkg holds:
  - typedef enum rst_seq_state_t {ASSERT, FILTER, RELEASE, GAP, DONE};
  - the counter-width localparam function (clog2 of the max of all cycle parameters, plus 1).
- One sub-module, uvmt_reset_st_rst_seq_cnt: a clear/enable counter with terminal-count compare, shared by ASSERT, FILTER, GAP and timeout.

Test Plan:
- Default params, reset_req=0, acks=1 -> rst_out[i] clears at cycles 12/15/18/21, seq_done=1 at 22, timeout_err=0.
- reset_req held 1 for 20 cycles after reset, then 0 -> ASSERT lasts 20 cycles, FILTER 4, rst_out[0] clears 4 cycles after reset_req falls.
- In FILTER, pulse reset_req 1 for 1 cycle at FILTER cnt=2 -> back to ASSERT; full MIN_ASSERT + FILTER repeated before any release.
- domain_ack[1] held 0 for 30 cycles -> rst_out[2] stays 1, cur_domain=1, busy=1; after ack, rst_out[2] clears GAP_CYCLES+1 cycles later.
- reset_req=1 in the same cycle as domain_ack[2] during RELEASE -> next edge rst_out=4'b1111, cur_domain=0, seq_done=0; abort wins.
- With UVMT_RESET_ST_RST_SEQ_ACK_TIMEOUT_EN, domain_ack[0]=0 forever -> timeout_err=1 after 64 RELEASE cycles, sequence continues to DONE. Without the macro -> stays in RELEASE indefinitely, timeout_err=0.
